// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Digit-serial sequencer that adds two packed BCD operands using one external
//   single-digit BCD adder. Operands are latched on an accepted start, then one
//   digit per cycle (least significant first) is presented to the adder while
//   the ripple carry is kept locally. Digits above 9 are flagged in o_err.
//
// Ports
//   i_clk, i_rst      rising-edge clock, synchronous active-high reset
//   i_start           request an addition (only honoured while idle)
//   i_a, i_b, i_cin   packed BCD operands (digit 0 in bits [3:0]) and carry in
//   o_add_a/b/cin     current digit pair and carry driven to the digit adder
//   i_add_s/cout      digit sum and carry returned by the digit adder
//   o_busy            high while running or signalling done
//   o_done            one-cycle pulse, o_sum/o_cout/o_err valid
//   o_sum, o_cout     packed BCD result and final carry, held until next start
//   o_err             some operand digit was above 9 in the last operation
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  input  logic                  i_cin,
  output logic [3:0]            o_add_a,
  output logic [3:0]            o_add_b,
  output logic                  o_add_cin,
  input  logic [3:0]            i_add_s,
  input  logic                  i_add_cout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_err
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t              r_state;
  logic [IdxW-1:0]     r_idx;
  logic                r_carry;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_cout;
  logic                r_err;
  logic                r_busy;
  logic                r_done;

  logic [3:0]          w_a;
  logic [3:0]          w_b;
  logic                w_bad;

  // Digit select from the latched operands; forced to zero outside RUN so the
  // adder inputs never follow the live operand ports.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (r_state == StRun) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_idx == IdxW'(i)) begin
          w_a = r_a[4*i +: 4];
          w_b = r_b[4*i +: 4];
        end
      end
    end
  end

  assign w_bad     = (w_a > 4'd9) || (w_b > 4'd9);
  assign o_add_a   = w_a;
  assign o_add_b   = w_b;
  assign o_add_cin = (r_state == StRun) ? r_carry : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IdxW'(i)) r_sum[4*i +: 4] <= i_add_s;
          end
          r_carry <= i_add_cout;
          r_err   <= r_err | w_bad;
          if (r_idx == IdxW'(DIGITS - 1)) begin
            r_cout  <= i_add_cout;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_err  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl with DIGITS=4 and a behavioural BCD digit adder.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .i_add_s    (add_s),
    .i_add_cout (add_cout),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_err      (err)
  );

  // Single-digit BCD adder: binary sum, +6 correction when above 9.
  logic [4:0] t;
  logic [4:0] tc;
  always_comb begin
    t  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    tc = t + 5'd6;
    if (t > 5'd9) begin
      add_s    = tc[3:0];
      add_cout = 1'b1;
    end else begin
      add_s    = t[3:0];
      add_cout = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait for done (bounded), check result, timing and return to idle.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input logic [15:0] es, input logic ec, input logic ee);
    int n;
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done_latency", n, DIGITS);
    chk("sum", {16'b0, sum}, {16'b0, es});
    chk("cout", {31'b0, cout}, {31'b0, ec});
    chk("err", {31'b0, err}, {31'b0, ee});
    chk("busy_in_done", {31'b0, busy}, 32'd1);
    tick();
    chk("done_pulse_len", {31'b0, done}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("sum_held", {16'b0, sum}, {16'b0, es});
    chk("add_a_idle", {28'b0, add_a}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] va, vb;
    logic        vc;
    logic [15:0] es;
    logic        ec, ee;
  } vec_t;

  vec_t vecs[9];
  int   dcount;

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'h0358, 16'h0642, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[2] = '{16'h0358, 16'h0642, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[3] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h000A, 16'h0003, 1'b1, 16'h0014, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0999, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[8] = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_add", {23'b0, add_a, add_b, add_cin}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, vecs[i].ee);
    end

    // Start during RUN and DONE is ignored; operand changes during RUN too.
    a = 16'h0358; b = 16'h0642; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h9999; b = 16'h9999; cin = 1'b1;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      start = (c == 1) || done;
      tick();
      if (done) dcount++;
    end
    start = 1'b0;
    chk("ignored_start_dones", dcount, 1);
    chk("ignored_start_sum", {16'b0, sum}, 32'h1000);
    chk("ignored_start_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of RUN aborts without a done.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("idx2_add_a", {28'b0, add_a}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    run_op(16'h0358, 16'h0642, 1'b1, 16'h1001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
